// File: rtl/hit_sequencer.sv
// Drum-hit request FIFO and dispatcher for a single stepper hit actuator.
// Optional statistics counters are enabled with HIT_SEQUENCER_STATS_EN.
module hit_sequencer #(
  parameter int DEPTH              = 8,
  parameter int VEL_MAX            = 32,
  parameter int START_PULSE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES     = 50_000_000
) (
  input  logic                     i_clk_50,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  input  logic [7:0]               i_req_velocity,
  output logic                     o_req_ready,
  input  logic                     i_zdone,
  output logic                     o_start_n,
  output logic [7:0]               o_hit_velocity,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic [15:0]              o_hit_count,
  output logic [15:0]              o_reject_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0]    VEL_CLAMP  = 8'(VEL_MAX);
  localparam logic [31:0]   PULSE_LOAD = 32'(START_PULSE_CYCLES);
  localparam logic [31:0]   HOLD_LOAD  = 32'(HOLDOFF_CYCLES);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

  typedef enum logic [1:0] {S_HOME, S_IDLE, S_START, S_HOLD} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   timer_reg, timer_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push, pop;
  logic [7:0]    push_vel;
  logic          start_n_reg, start_n_next;
  logic          busy_reg, busy_next;
  logic [7:0]    hit_vel_reg;

  assign o_req_ready = (count_reg < DEPTH_C);
  // Zero-velocity requests are consumed without occupying a slot.
  assign push        = i_req_valid && o_req_ready && (i_req_velocity != 8'd0);
  assign push_vel    = (i_req_velocity > VEL_CLAMP) ? VEL_CLAMP : i_req_velocity;

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    pop          = 1'b0;
    start_n_next = (state_reg != S_START);
    busy_next    = (state_reg == S_START) || (state_reg == S_HOLD);
    case (state_reg)
      S_HOME: begin
        if (i_zdone) state_next = S_IDLE;
      end
      S_IDLE: begin
        if ((count_reg != '0) && i_zdone) begin
          pop        = 1'b1;
          timer_next = PULSE_LOAD;
          state_next = S_START;
        end
      end
      S_START: begin
        if (timer_reg <= 32'd1) begin
          timer_next = HOLD_LOAD;
          state_next = S_HOLD;
        end else begin
          timer_next = timer_reg - 32'd1;
        end
      end
      S_HOLD: begin
        if (timer_reg <= 32'd1) begin
          timer_next = '0;
          state_next = S_IDLE;
        end else begin
          timer_next = timer_reg - 32'd1;
        end
      end
      default: state_next = S_HOME;
    endcase
  end

  always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= S_HOME;
      timer_reg   <= '0;
      start_n_reg <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      start_n_reg <= start_n_next;
      busy_reg    <= busy_next;
    end
  end

  // Storage array is left unreset so it maps onto block RAM.
  always_ff @(posedge i_clk_50) begin
    if (push) mem[wr_ptr_reg] <= push_vel;
  end

  always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      hit_vel_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + AW'(1);
        hit_vel_reg <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign o_start_n      = start_n_reg;
  assign o_busy         = busy_reg;
  assign o_hit_velocity = hit_vel_reg;
  assign o_fifo_count   = count_reg;

`ifdef HIT_SEQUENCER_STATS_EN
  logic        reject;
  logic [15:0] hit_count_reg, reject_count_reg;

  assign reject = i_req_valid && o_req_ready && (i_req_velocity == 8'd0);

  // Both counters saturate rather than wrap.
  always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_count_reg    <= '0;
      reject_count_reg <= '0;
    end else begin
      if (pop && (hit_count_reg != 16'hFFFF))
        hit_count_reg <= hit_count_reg + 16'd1;
      if (reject && (reject_count_reg != 16'hFFFF))
        reject_count_reg <= reject_count_reg + 16'd1;
    end
  end

  assign o_hit_count    = hit_count_reg;
  assign o_reject_count = reject_count_reg;
`else
  assign o_hit_count    = '0;
  assign o_reject_count = '0;
`endif

endmodule

// File: tb/tb_hit_sequencer.sv
// Scoreboard bench for hit_sequencer: stimulus queues expected dispatch velocities,
// a monitor checks each start pulse against them.
module tb_hit_sequencer;

`ifdef HIT_SEQUENCER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [7:0]  req_velocity;
  logic        req_ready;
  logic        zdone;
  logic        start_n;
  logic [7:0]  hit_velocity;
  logic        busy;
  logic [3:0]  fifo_count;
  logic [15:0] hit_count;
  logic [15:0] reject_count;

  hit_sequencer #(
    .DEPTH(8), .VEL_MAX(32), .START_PULSE_CYCLES(4), .HOLDOFF_CYCLES(20)
  ) dut (
    .i_clk_50(clk), .i_rst_n(rst_n), .i_req_valid(req_valid),
    .i_req_velocity(req_velocity), .o_req_ready(req_ready), .i_zdone(zdone),
    .o_start_n(start_n), .o_hit_velocity(hit_velocity), .o_busy(busy),
    .o_fifo_count(fifo_count), .o_hit_count(hit_count), .o_reject_count(reject_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int falls = 0;
  int sb[$];
  int fall_q[$];
  int gap_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int eh(input int n);
    return STATS ? n : 0;
  endfunction

  // Monitor: pulse order, velocity, width and busy gaps
  bit prev_start = 1'b1;
  bit prev_busy = 1'b0;
  bit in_pulse = 1'b0;
  int low_cnt = 0;
  int busy_low = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b1;
      prev_busy  = 1'b0;
      in_pulse   = 1'b0;
      low_cnt    = 0;
      busy_low   = 0;
    end else begin
      if (prev_start && !start_n) begin
        falls++;
        fall_q.push_back(cyc);
        in_pulse = 1'b1;
        low_cnt  = 0;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got vel %0d, expected no pulse", hit_velocity);
        end else begin
          int e;
          e = sb.pop_front();
          $display("dispatch vel=%0d expected=%0d cyc=%0d", hit_velocity, e, cyc);
          chk("hit_velocity", 32'(hit_velocity), 32'(e));
        end
        chk("busy_with_start", 32'(busy), 32'd1);
      end
      if (!start_n) low_cnt++;
      if (!prev_start && start_n && in_pulse) begin
        chk("pulse_len", 32'(low_cnt), 32'd4);
        in_pulse = 1'b0;
      end
      if (!busy) busy_low++;
      if (!prev_busy && busy) gap_q.push_back(busy_low);
      if (busy) busy_low = 0;
      prev_start = start_n;
      prev_busy  = busy;
    end
  end

  task automatic push_req(input logic [7:0] v, input int expv);
    @(negedge clk);
    req_valid    = 1'b1;
    req_velocity = v;
    $display("push vel=%0d ready=%0d count=%0d", v, req_ready, fifo_count);
    if (req_ready && v != 8'd0) sb.push_back(expv);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sb.size() == 0 && !busy && start_n && fifo_count == 0) && n < 3000);
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending, expected 0", nm, sb.size());
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int f0;
    int n;
    rst_n = 1'b0;
    zdone = 1'b0;
    req_valid = 1'b0;
    req_velocity = 8'd0;

    // Reset values
    wait_cycles(3);
    chk("rst_start_n", 32'(start_n), 32'd1);
    chk("rst_hit_vel", 32'(hit_velocity), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_rejects", 32'(reject_count), 32'd0);
    rst_n = 1'b1;

    // 1: homing gate
    push_req(8'd10, 10);
    wait_cycles(10);
    chk("s1_count_held", 32'(fifo_count), 32'd1);
    chk("s1_no_pulse", 32'(falls), 32'd0);
    zdone = 1'b1;
    wait_idle("s1");
    chk("s1_hits", 32'(hit_count), 32'(eh(1)));

    // 2: back-to-back 5,6,7
    fall_q.delete();
    gap_q.delete();
    push_req(8'd5, 5);
    push_req(8'd6, 6);
    push_req(8'd7, 7);
    wait_idle("s2");
    chk("s2_pulses", 32'(fall_q.size()), 32'd3);
    if (fall_q.size() == 3) begin
      chk("s2_gap01", 32'(fall_q[1] - fall_q[0]), 32'd25);
      chk("s2_gap12", 32'(fall_q[2] - fall_q[1]), 32'd25);
    end
    chk("s2_busy_events", 32'(gap_q.size()), 32'd3);
    if (gap_q.size() == 3) begin
      chk("s2_busy_gap1", 32'(gap_q[1]), 32'd1);
      chk("s2_busy_gap2", 32'(gap_q[2]), 32'd1);
    end
    chk("s2_hits", 32'(hit_count), 32'(eh(4)));

    // 3: reject zero, clamp 200 -> 32
    f0 = falls;
    push_req(8'd0, 0);
    @(negedge clk);
    chk("s3_reject_count", 32'(reject_count), 32'(eh(1)));
    chk("s3_zero_not_queued", 32'(fifo_count), 32'd0);
    push_req(8'd200, 32);
    wait_idle("s3");
    chk("s3_one_pulse", 32'(falls - f0), 32'd1);
    chk("s3_hits", 32'(hit_count), 32'(eh(5)));

    // 4: fill while not homed
    zdone = 1'b0;
    for (int i = 1; i <= 8; i++) push_req(8'(i), i);
    @(negedge clk);
    chk("s4_full_count", 32'(fifo_count), 32'd8);
    chk("s4_full_ready", 32'(req_ready), 32'd0);
    push_req(8'd9, 9);
    @(negedge clk);
    chk("s4_ninth_dropped", 32'(fifo_count), 32'd8);
    chk("s4_sb_depth", 32'(sb.size()), 32'd8);
    zdone = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fifo_count == 4'd8 && n < 20);
    chk("s4_first_pop_count", 32'(fifo_count), 32'd7);
    chk("s4_ready_after_pop", 32'(req_ready), 32'd1);
    wait_idle("s4");
    chk("s4_hits", 32'(hit_count), 32'(eh(13)));
    chk("s4_rejects", 32'(reject_count), 32'(eh(1)));

    // 5: async reset during second pulse clock
    push_req(8'd9, 9);
    push_req(8'd11, 11);
    push_req(8'd12, 12);
    n = 0;
    while (start_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("s5_pulse_seen", 32'(start_n), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async_start_n", 32'(start_n), 32'd1);
    chk("s5_flush_count", 32'(fifo_count), 32'd0);
    chk("s5_busy_cleared", 32'(busy), 32'd0);
    chk("s5_hits_cleared", 32'(hit_count), 32'd0);
    sb.delete();
    zdone = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    f0 = falls;
    wait_cycles(30);
    zdone = 1'b1;
    wait_cycles(30);
    chk("s5_no_pulse_after_reset", 32'(falls - f0), 32'd0);
    push_req(8'd15, 15);
    wait_idle("s5");
    chk("s5_new_pulse", 32'(falls - f0), 32'd1);
    chk("s5_hits", 32'(hit_count), 32'(eh(1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hit_sequencer.md
# hit_sequencer

Queues drum-hit requests and dispatches them one at a time to a single stepper-motor hit actuator. Each dispatch is a timed active-low start pulse plus a hit velocity. The block sits between the note/event source and the actuator. It gates dispatch until the actuator reports homing complete. It enforces a hold-off after every hit so a new start never lands during the actuator's hit or return motion. It also sanitises velocity: zero velocity is rejected and large values are clamped.

## Interface
Parameters:
- DEPTH, 8: request FIFO entries (power of two, ≥2)
- VEL_MAX, 32: upper clamp for dispatched velocity (1..255)
- START_PULSE_CYCLES, 4: o_start_n low duration in clocks (≥1)
- HOLDOFF_CYCLES, 50_000_000: clocks after pulse end before next dispatch (≥1, fits 32 bits)

Ports (one clock; reset is asynchronous and active-low):
- i_clk_50  in  1  system clock, 50 MHz
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  hit request present
- i_req_velocity  in  8  requested hit velocity
- o_req_ready  out  1  FIFO can accept (count < DEPTH)
- i_zdone  in  1  actuator homed (level, high = homed)
- o_start_n  out  1  active-low start to actuator
- o_hit_velocity  out  8  velocity of current/last dispatch, stable while o_start_n low and through hold-off
- o_busy  out  1  high in S_START or S_HOLD
- o_fifo_count  out  $clog2(DEPTH)+1  queued entries
- o_hit_count  out  16  dispatched hits (see Configuration)
- o_reject_count  out  16  zero-velocity requests discarded (see Configuration)

## Operation
- Reset values: o_start_n=1, o_hit_velocity=0, o_busy=0, o_fifo_count=0, o_req_ready=1, counters=0, state S_HOME.
- Accept when i_req_valid && o_req_ready at a rising edge.
  - Velocity 0: the request is consumed but not written, and o_reject_count increments.
  - Otherwise write min(i_req_velocity, VEL_MAX).
- o_req_ready = (count < DEPTH), combinational from count only. When full, a same-cycle pop does not enable a write.
- Simultaneous push and pop with count in 1..DEPTH-1: count is unchanged and FIFO order is preserved.
- States:
  - S_HOME: wait for i_zdone=1, then go to S_IDLE.
  - S_IDLE: if count>0 and i_zdone=1, pop the head, latch it to o_hit_velocity, load the pulse counter, go to S_START.
  - S_START: o_start_n=0 for START_PULSE_CYCLES clocks, then load the hold-off counter and go to S_HOLD.
  - S_HOLD: count down HOLDOFF_CYCLES clocks, then go to S_IDLE.
- i_zdone falling in S_START or S_HOLD: the current sequence completes normally, and dispatch is then blocked in S_IDLE until i_zdone=1. No return to S_HOME.
- Counters are 16-bit and saturate at 0xFFFF; they do not wrap.
- Asynchronous reset mid-pulse: o_start_n goes high immediately and the FIFO is flushed.

## Timing
- Request accepted at edge N into an empty FIFO with the block in S_IDLE and i_zdone=1:
  - count=1 after N
  - pop at N+1
  - o_start_n low from N+2 for exactly START_PULSE_CYCLES clocks
- o_busy rises with o_start_n falling. It falls HOLDOFF_CYCLES clocks after o_start_n rises.
- Back-to-back queued hits: rising edge of o_start_n to next falling edge = HOLDOFF_CYCLES+1 clocks.
- o_hit_velocity updates only on the pop edge.
- All outputs are registered except o_req_ready.

## Configuration
- HIT_SEQUENCER_STATS_EN:
  - Defined: o_hit_count (increments on each pop) and o_reject_count are implemented.
  - Undefined: both outputs are tied to 0 and no counter flops are present. All other behaviour is identical.

## Test plan
- Reset, hold i_zdone=0, push velocity 10 → o_start_n stays 1, o_fifo_count=1. Raise i_zdone → start pulse with o_hit_velocity=10 and 4 clocks low.
- With i_zdone=1 and HOLDOFF_CYCLES=20, push 5, 6, 7 back-to-back → three pulses in order 5, 6, 7, falling edges 25 clocks apart, o_busy gaps of 1 clock.
- Push velocity 0, then 200 with VEL_MAX=32 → first is rejected (o_reject_count=1, no pulse); second dispatches as 32.
- With i_zdone=0, fill 8 entries → o_req_ready=0, a 9th valid is not accepted, count stays 8. Raise i_zdone → ready=1 one clock after the first pop.
- Assert i_rst_n=0 during the second pulse clock → o_start_n=1 asynchronously, count=0, state S_HOME. After release, no pulse until i_zdone=1 and a new push.
- Build without HIT_SEQUENCER_STATS_EN, repeat scenario 2 → o_hit_count=0 throughout and pulses unchanged.
